// File: rtl/tlb_op_sched_if.sv
// Bundle of the WB-stage handshake, the TLB maintenance port and the CSR
// write-back signals used by the TLB maintenance sequencer.
interface tlb_op_sched_if #(
   parameter int IDXW = 4
);
   // WB-stage request
   logic            op_valid;
   logic [2:0]      op_code;
   logic [4:0]      op_inv_type;
   logic [31:0]     op_pc;
   logic            cancel;
   logic [IDXW-1:0] csr_tlbidx_index;
   logic            op_ready;
   logic            busy;
   logic            op_done;
   // TLB maintenance port
   logic            tlb_s_req;
   logic            tlb_s_found;
   logic [IDXW-1:0] tlb_s_index;
   logic [IDXW-1:0] tlb_r_index;
   logic            tlb_we;
   logic [IDXW-1:0] tlb_w_index;
   logic            tlb_inv_valid;
   logic [4:0]      tlb_inv_op;
   // CSR write-back and refetch
   logic            csr_tlbidx_we;
   logic            csr_tlbidx_ne;
   logic            csr_tlbidx_index_we;
   logic [IDXW-1:0] csr_tlbidx_index_o;
   logic            csr_tlbrd_we;
   logic            refetch_flush;
   logic [31:0]     refetch_pc;

   // The sequencer side
   modport slave (
      input  op_valid, op_code, op_inv_type, op_pc, cancel, csr_tlbidx_index,
             tlb_s_found, tlb_s_index,
      output op_ready, busy, op_done, tlb_s_req, tlb_r_index, tlb_we,
             tlb_w_index, tlb_inv_valid, tlb_inv_op, csr_tlbidx_we,
             csr_tlbidx_ne, csr_tlbidx_index_we, csr_tlbidx_index_o,
             csr_tlbrd_we, refetch_flush, refetch_pc
   );

   // The pipeline / TLB / CSR side
   modport master (
      output op_valid, op_code, op_inv_type, op_pc, cancel, csr_tlbidx_index,
             tlb_s_found, tlb_s_index,
      input  op_ready, busy, op_done, tlb_s_req, tlb_r_index, tlb_we,
             tlb_w_index, tlb_inv_valid, tlb_inv_op, csr_tlbidx_we,
             csr_tlbidx_ne, csr_tlbidx_index_we, csr_tlbidx_index_o,
             csr_tlbrd_we, refetch_flush, refetch_pc
   );
endinterface

// File: rtl/tlb_op_sched.sv
// TLB maintenance sequencer: accepts one TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB
// at writeback, drives the TLB maintenance port, writes results to the CSRs
// and raises the pc+4 refetch flush after state-changing instructions.
module tlb_op_sched #(
   parameter int TLBNUM  = 16,
   parameter int IDXW    = 4,
   parameter int TLB_LAT = 1
) (
   input  logic           clk,
   input  logic           resetn,
   tlb_op_sched_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FLUSH} state_e;

   localparam logic [2:0] OP_SRCH = 3'd1;
   localparam logic [2:0] OP_RD   = 3'd2;
   localparam logic [2:0] OP_WR   = 3'd3;
   localparam logic [2:0] OP_FILL = 3'd4;
   localparam logic [2:0] OP_INV  = 3'd5;

   // The wait counter holds TLB_LAT-1 down to 0.
   localparam int              LATW     = (TLB_LAT > 1) ? $clog2(TLB_LAT) : 1;
   localparam logic [LATW-1:0] LAT_LOAD = LATW'(TLB_LAT - 1);

   state_e          state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic [31:0]     pc_q, pc_d;
   logic [4:0]      inv_q, inv_d;
   logic [LATW-1:0] wait_q, wait_d;
   logic [IDXW-1:0] ridx_q, ridx_d;
   logic [IDXW-1:0] fill_q;

   logic legal_op;
   assign legal_op = (bus.op_code != 3'd0) && (bus.op_code <= OP_INV);

   // State and latched-operation registers.
   // NOTE: every register here, including the latched pc, has a defined
   // reset value so the block comes out of reset fully deterministic.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         pc_q    <= '0;
         inv_q   <= '0;
         wait_q  <= '0;
         ridx_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all
         // registers update together from pre-edge values.
         state_q <= state_d;
         op_q    <= op_d;
         pc_q    <= pc_d;
         inv_q   <= inv_d;
         wait_q  <= wait_d;
         ridx_q  <= ridx_d;
      end
   end

   // Free-running fill pointer used as the TLBFILL victim index.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                          fill_q <= '0;
      else if (fill_q == IDXW'(TLBNUM - 1)) fill_q <= '0;
      else                                  fill_q <= fill_q + IDXW'(1);
   end

   // Next-state and output decode.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case statement can infer a latch.
      state_d                 = state_q;
      op_d                    = op_q;
      pc_d                    = pc_q;
      inv_d                   = inv_q;
      wait_d                  = wait_q;
      ridx_d                  = ridx_q;
      bus.op_ready            = (state_q == S_IDLE);
      bus.busy                = (state_q != S_IDLE);
      bus.op_done             = 1'b0;
      bus.tlb_s_req           = 1'b0;
      bus.tlb_r_index         = '0;
      bus.tlb_we              = 1'b0;
      bus.tlb_w_index         = '0;
      bus.tlb_inv_valid       = 1'b0;
      bus.tlb_inv_op          = '0;
      bus.csr_tlbidx_we       = 1'b0;
      bus.csr_tlbidx_ne       = 1'b0;
      bus.csr_tlbidx_index_we = 1'b0;
      bus.csr_tlbidx_index_o  = '0;
      bus.csr_tlbrd_we        = 1'b0;
      bus.refetch_flush       = 1'b0;
      bus.refetch_pc          = '0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.op_valid && legal_op && !bus.cancel) begin
               op_d    = bus.op_code;
               pc_d    = bus.op_pc;
               inv_d   = bus.op_inv_type;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            unique case (op_q)
               OP_SRCH: begin
                  bus.tlb_s_req = 1'b1;
                  wait_d        = LAT_LOAD;
                  state_d       = S_WAIT;
               end
               OP_RD: begin
                  bus.tlb_r_index = bus.csr_tlbidx_index;
                  ridx_d          = bus.csr_tlbidx_index;
                  wait_d          = LAT_LOAD;
                  state_d         = S_WAIT;
               end
               OP_WR: begin
                  bus.tlb_we      = 1'b1;
                  bus.tlb_w_index = bus.csr_tlbidx_index;
                  state_d         = S_FLUSH;
               end
               OP_FILL: begin
                  bus.tlb_we      = 1'b1;
                  bus.tlb_w_index = fill_q;
                  state_d         = S_FLUSH;
               end
               OP_INV: begin
                  bus.tlb_inv_valid = 1'b1;
                  bus.tlb_inv_op    = inv_q;
                  state_d           = S_FLUSH;
               end
               default: state_d = S_IDLE;
            endcase
         end
         S_WAIT: begin
            // The read index stays stable while the TLB read completes.
            if (op_q == OP_RD) bus.tlb_r_index = ridx_q;
            if (wait_q == '0) begin
               if (op_q == OP_SRCH) begin
                  bus.csr_tlbidx_we = 1'b1;
                  bus.csr_tlbidx_ne = ~bus.tlb_s_found;
                  if (bus.tlb_s_found) begin
                     bus.csr_tlbidx_index_we = 1'b1;
                     bus.csr_tlbidx_index_o  = bus.tlb_s_index;
                  end
                  bus.op_done = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  bus.csr_tlbrd_we = 1'b1;
                  state_d          = S_FLUSH;
               end
            end else begin
               wait_d = wait_q - LATW'(1);
            end
         end
         S_FLUSH: begin
            bus.refetch_flush = 1'b1;
            bus.refetch_pc    = pc_q + 32'd4;
            bus.op_done       = 1'b1;
            state_d           = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A flush from the exception/ertn path kills the op in flight.
      if ((state_q != S_IDLE) && bus.cancel) begin
         bus.op_done             = 1'b0;
         bus.tlb_s_req           = 1'b0;
         bus.tlb_we              = 1'b0;
         bus.tlb_w_index         = '0;
         bus.tlb_inv_valid       = 1'b0;
         bus.tlb_inv_op          = '0;
         bus.csr_tlbidx_we       = 1'b0;
         bus.csr_tlbidx_ne       = 1'b0;
         bus.csr_tlbidx_index_we = 1'b0;
         bus.csr_tlbidx_index_o  = '0;
         bus.csr_tlbrd_we        = 1'b0;
         bus.refetch_flush       = 1'b0;
         bus.refetch_pc          = '0;
         state_d                 = S_IDLE;
      end
   end

endmodule

// File: tb/tb_tlb_op_sched.sv
// Scoreboard bench for tlb_op_sched: the driver pushes the expected output
// events of each op; a negedge monitor pops and compares every cycle in
// which the DUT drives any strobe, CSR write, flush or done.
module tb_tlb_op_sched;

   localparam int IDXW    = 4;
   localparam int TLBNUM  = 16;
   localparam int TLB_LAT = 3;

   localparam logic [2:0] SRCH = 3'd1, RD = 3'd2, WR = 3'd3, FILL = 3'd4, INV = 3'd5;

   typedef struct packed {
      logic [15:0] cyc;
      logic        s_req;
      logic        we;
      logic [3:0]  w_index;
      logic        inv_valid;
      logic [4:0]  inv_op;
      logic        idx_we;
      logic        ne;
      logic        index_we;
      logic [3:0]  index_o;
      logic        rd_we;
      logic [3:0]  r_index;
      logic        flush;
      logic [31:0] rpc;
      logic        done;
   } ev_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   cyc;
   int   n_checks = 0;
   int   n_errors = 0;
   ev_t  exp_q[$];

   tlb_op_sched_if #(.IDXW(IDXW)) bus ();

   tlb_op_sched #(.TLBNUM(TLBNUM), .IDXW(IDXW), .TLB_LAT(TLB_LAT)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Cycle number since reset release; the fill pointer model is cyc mod TLBNUM.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [8:0] strobes();
      return {bus.busy, bus.tlb_s_req, bus.tlb_we, bus.tlb_inv_valid, bus.csr_tlbidx_we,
              bus.csr_tlbidx_index_we, bus.csr_tlbrd_we, bus.refetch_flush, bus.op_done};
   endfunction

   // Monitor: one comparison per active output cycle; fields that only
   // carry meaning alongside their strobe are masked otherwise.
   always @(negedge clk) begin
      ev_t obs;
      ev_t e;
      if (resetn && (bus.tlb_s_req | bus.tlb_we | bus.tlb_inv_valid | bus.csr_tlbidx_we |
                     bus.csr_tlbrd_we | bus.refetch_flush | bus.op_done)) begin
         obs           = '0;
         obs.cyc       = 16'(cyc);
         obs.s_req     = bus.tlb_s_req;
         obs.we        = bus.tlb_we;
         obs.w_index   = bus.tlb_we ? bus.tlb_w_index : 4'd0;
         obs.inv_valid = bus.tlb_inv_valid;
         obs.inv_op    = bus.tlb_inv_valid ? bus.tlb_inv_op : 5'd0;
         obs.idx_we    = bus.csr_tlbidx_we;
         obs.ne        = bus.csr_tlbidx_we ? bus.csr_tlbidx_ne : 1'b0;
         obs.index_we  = bus.csr_tlbidx_index_we;
         obs.index_o   = bus.csr_tlbidx_index_we ? bus.csr_tlbidx_index_o : 4'd0;
         obs.rd_we     = bus.csr_tlbrd_we;
         obs.r_index   = bus.csr_tlbrd_we ? bus.tlb_r_index : 4'd0;
         obs.flush     = bus.refetch_flush;
         obs.rpc       = bus.refetch_flush ? bus.refetch_pc : 32'd0;
         obs.done      = bus.op_done;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event got=%h (t=%0t)", obs, $time);
         end else begin
            e = exp_q.pop_front();
            check("event", 128'(obs), 128'(e));
         end
      end
   end

   task automatic push_ev(input ev_t e, input int off, input int cancel_off);
      if (cancel_off == 0 || off < cancel_off) exp_q.push_back(e);
   endtask

   // Issue one op in the current cycle (T); cancel_off>0 raises cancel in
   // cycle T+cancel_off. Ends one cycle after the last expected activity.
   task automatic run_op(input logic [2:0] code, input logic [4:0] inv, input logic [31:0] pc,
                         input logic [3:0] idx, input logic found, input logic [3:0] sidx,
                         input int cancel_off);
      int  t;
      int  last;
      ev_t e;
      t                    = cyc;
      bus.csr_tlbidx_index = idx;
      bus.tlb_s_found      = found;
      bus.tlb_s_index      = sidx;
      bus.op_code          = code;
      bus.op_inv_type      = inv;
      bus.op_pc            = pc;
      bus.op_valid         = 1'b1;
      case (code)
         SRCH: begin
            e = '0; e.cyc = 16'(t + 1); e.s_req = 1'b1;
            push_ev(e, 1, cancel_off);
            e = '0; e.cyc = 16'(t + 1 + TLB_LAT); e.idx_we = 1'b1; e.ne = ~found;
            e.index_we = found; e.index_o = found ? sidx : 4'd0; e.done = 1'b1;
            push_ev(e, 1 + TLB_LAT, cancel_off);
            last = 1 + TLB_LAT;
         end
         RD: begin
            e = '0; e.cyc = 16'(t + 1 + TLB_LAT); e.rd_we = 1'b1; e.r_index = idx;
            push_ev(e, 1 + TLB_LAT, cancel_off);
            last = 2 + TLB_LAT;
         end
         default: begin
            e = '0; e.cyc = 16'(t + 1);
            if (code == INV) begin
               e.inv_valid = 1'b1; e.inv_op = inv;
            end else begin
               e.we = 1'b1;
               e.w_index = (code == WR) ? idx : 4'((t + 1) % TLBNUM);
            end
            push_ev(e, 1, cancel_off);
            last = 2;
         end
      endcase
      if (code != SRCH) begin
         e = '0; e.cyc = 16'(t + last); e.flush = 1'b1; e.rpc = pc + 32'd4; e.done = 1'b1;
         push_ev(e, last, cancel_off);
      end
      tick();
      bus.op_valid = 1'b0;
      bus.op_code  = 3'd0;
      if (cancel_off != 0) last = cancel_off;
      for (int k = 1; k <= last; k++) begin
         if (k == cancel_off) bus.cancel = 1'b1;
         tick();
         bus.cancel = 1'b0;
      end
      check("op_ready_after_op", 128'(bus.op_ready), 128'(1'b1));
      check("busy_after_op", 128'(bus.busy), 128'(1'b0));
   endtask

   initial begin
      bus.op_valid = 1'b0; bus.op_code = 3'd0; bus.op_inv_type = 5'd0; bus.op_pc = 32'd0;
      bus.cancel = 1'b0; bus.csr_tlbidx_index = 4'd0; bus.tlb_s_found = 1'b0;
      bus.tlb_s_index = 4'd0;
      #2;
      check("reset_op_ready", 128'(bus.op_ready), 128'(1'b1));
      check("reset_strobes", 128'(strobes()), 128'(9'd0));
      tick(); tick();
      resetn = 1'b1;

      // TLBFILL issued in cycle 8, then in cycle 23 (pointer wraps to 7).
      while (cyc < 7) tick();
      run_op(FILL, 5'd0, 32'h1C00_0040, 4'd0, 1'b0, 4'd0, 0);
      while (cyc < 22) tick();
      run_op(FILL, 5'd0, 32'h1C00_0080, 4'd0, 1'b0, 4'd0, 0);

      // TLBWR at index 5.
      run_op(WR, 5'd0, 32'h1C00_0100, 4'd5, 1'b0, 4'd0, 0);
      // TLBSRCH hit then miss.
      run_op(SRCH, 5'd0, 32'h1C00_0200, 4'd0, 1'b1, 4'd9, 0);
      run_op(SRCH, 5'd0, 32'h1C00_0204, 4'd0, 1'b0, 4'd9, 0);
      // INVTLB type 3 cancelled in FLUSH, TLBRD cancelled in its last WAIT cycle.
      run_op(INV, 5'd3, 32'h1C00_0300, 4'd0, 1'b0, 4'd0, 2);
      run_op(RD, 5'd0, 32'h1C00_0400, 4'd6, 1'b0, 4'd0, 1 + TLB_LAT);
      // Uncancelled INVTLB type 5.
      run_op(INV, 5'd5, 32'h1C00_0500, 4'd0, 1'b0, 4'd0, 0);

      // Illegal codes and a cancelled request are never accepted.
      for (int i = 0; i < 3; i++) begin
         bus.op_valid = 1'b1;
         bus.op_code  = (i == 2) ? 3'd0 : 3'd6;
         tick();
         check("illegal_op_ready", 128'(bus.op_ready), 128'(1'b1));
         check("illegal_strobes", 128'(strobes()), 128'(9'd0));
      end
      bus.op_code = WR; bus.cancel = 1'b1;
      tick();
      bus.op_valid = 1'b0; bus.cancel = 1'b0;
      check("cancel_idle_not_accepted", 128'(bus.busy), 128'(1'b0));

      // TLBRD with pc wrap on the refetch target.
      run_op(RD, 5'd0, 32'hFFFF_FFFC, 4'd11, 1'b0, 4'd0, 0);

      // Reset asserted asynchronously during WAIT of a TLBRD.
      bus.op_code = RD; bus.csr_tlbidx_index = 4'd2; bus.op_valid = 1'b1;
      tick();
      bus.op_valid = 1'b0;
      tick(); tick();
      check("rd_in_wait_busy", 128'(bus.busy), 128'(1'b1));
      #2 resetn = 1'b0;
      #1;
      check("midreset_op_ready", 128'(bus.op_ready), 128'(1'b1));
      check("midreset_strobes", 128'(strobes()), 128'(9'd0));
      check("midreset_r_index", 128'(bus.tlb_r_index), 128'(4'd0));
      tick(); tick();
      resetn = 1'b1;
      // Fill pointer restarted from zero: issue in cycle 3 writes entry 3.
      while (cyc < 2) tick();
      run_op(FILL, 5'd0, 32'h1C00_0600, 4'd0, 1'b0, 4'd0, 0);

      tick(); tick();
      check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
